// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable clock divider with duty cycle, tick and config handshake
module prog_clock_divider #(
  parameter int REFERENCE_CLOCK   = 50_000_000,
  parameter int DEFAULT_FREQUENCY = 100,
  parameter int DEFAULT_DIVISOR   = REFERENCE_CLOCK / DEFAULT_FREQUENCY,
  parameter int NBITS             = 26
) (
  input  logic             clk_FPGA,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [NBITS-1:0] cfg_divisor,
  input  logic [NBITS-1:0] cfg_high,
  output logic             cfg_pending,
  output logic             clock_signal,
  output logic             tick
);

  localparam logic [NBITS-1:0] DIV_RST  = NBITS'(DEFAULT_DIVISOR);
  localparam logic [NBITS-1:0] HIGH_RST = NBITS'(DEFAULT_DIVISOR / 2);
  localparam logic [NBITS-1:0] DIV_MIN  = NBITS'(2);
  localparam logic [NBITS-1:0] ONE      = NBITS'(1);

  logic [NBITS-1:0] cnt, cnt_n;
  logic [NBITS-1:0] div_active, div_n;
  logic [NBITS-1:0] high_active, high_n;
  logic [NBITS-1:0] div_shadow, div_shadow_n;
  logic [NBITS-1:0] high_shadow, high_shadow_n;
  logic [NBITS-1:0] cfg_div_clamped;
  logic             pending_n;
  logic             tick_n;
  logic             clock_n;
  logic             xfer;
  logic             wrap;

  assign cfg_ready = !cfg_pending;

  // Next-state: counting, config capture, apply at period boundary or restart, output rule on next values
  always_comb begin
    cnt_n         = cnt;
    div_n         = div_active;
    high_n        = high_active;
    div_shadow_n  = div_shadow;
    high_shadow_n = high_shadow;
    pending_n     = cfg_pending;
    tick_n        = 1'b0;
    clock_n       = 1'b0;

    xfer            = cfg_valid && !cfg_pending;
    cfg_div_clamped = (cfg_divisor < DIV_MIN) ? DIV_MIN : cfg_divisor;
    wrap            = (cnt == div_active - ONE);

    if (xfer) begin
      div_shadow_n  = cfg_div_clamped;
      high_shadow_n = cfg_high;
    end

    if (restart) begin
      // Restart starts a fresh period; whatever configuration is available takes effect now
      cnt_n = '0;
      if (cfg_pending) begin
        div_n  = div_shadow;
        high_n = high_shadow;
      end else if (xfer) begin
        div_n  = cfg_div_clamped;
        high_n = cfg_high;
      end
      pending_n = 1'b0;
    end else begin
      if (enable) begin
        if (wrap) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (cfg_pending) begin
            div_n  = div_shadow;
            high_n = high_shadow;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      // A transfer coinciding with a wrap only becomes pending; it applies at the following wrap
      pending_n = xfer || (cfg_pending && !(enable && wrap));
    end

    // Low phase first; high >= divisor saturates to constant high, high = 0 gives constant low
    if (high_n >= div_n) begin
      clock_n = 1'b1;
    end else begin
      clock_n = (cnt_n >= div_n - high_n);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      div_active   <= DIV_RST;
      high_active  <= HIGH_RST;
      div_shadow   <= '0;
      high_shadow  <= '0;
      cfg_pending  <= 1'b0;
      clock_signal <= 1'b0;
      tick         <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      div_active   <= div_n;
      high_active  <= high_n;
      div_shadow   <= div_shadow_n;
      high_shadow  <= high_shadow_n;
      cfg_pending  <= pending_n;
      clock_signal <= clock_n;
      tick         <= tick_n;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider with directed and random steps
module tb_prog_clock_divider;

  localparam int NB      = 8;
  localparam int DEF_DIV = 10;

  logic          clk_FPGA    = 1'b0;
  logic          reset       = 1'b0;
  logic          enable      = 1'b0;
  logic          restart     = 1'b0;
  logic          cfg_valid   = 1'b0;
  logic [NB-1:0] cfg_divisor = '0;
  logic [NB-1:0] cfg_high    = '0;
  logic          cfg_ready;
  logic          cfg_pending;
  logic          clock_signal;
  logic          tick;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position in period plus active and waiting settings
  int m_pos, m_div, m_high, m_wait_div, m_wait_high;
  bit m_wait, m_tick;

  prog_clock_divider #(
    .REFERENCE_CLOCK  (1000),
    .DEFAULT_FREQUENCY(100),
    .NBITS            (NB)
  ) dut (
    .clk_FPGA    (clk_FPGA),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divisor (cfg_divisor),
    .cfg_high    (cfg_high),
    .cfg_pending (cfg_pending),
    .clock_signal(clock_signal),
    .tick        (tick)
  );

  // 10 ns clock
  always #5 clk_FPGA = ~clk_FPGA;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_div = DEF_DIV; m_high = DEF_DIV / 2;
    m_wait_div = 0; m_wait_high = 0; m_wait = 0; m_tick = 0;
  endtask

  // Output is high during the last m_high cycles of each m_div-cycle period
  function automatic bit model_clk();
    int low_len;
    low_len = (m_high >= m_div) ? 0 : m_div - m_high;
    return (m_pos >= low_len);
  endfunction

  task automatic model_update(input bit en, input bit rs, input bit v, input int d, input int h);
    bit accept;
    int cd;
    accept = v && !m_wait;
    cd     = (d < 2) ? 2 : d;
    m_tick = 0;
    if (rs) begin
      m_pos = 0;
      if (m_wait) begin m_div = m_wait_div; m_high = m_wait_high; end
      else if (accept) begin m_div = cd; m_high = h; end
      m_wait = 0;
    end else begin
      if (en) begin
        m_pos = (m_pos + 1) % m_div;
        if (m_pos == 0) begin
          m_tick = 1;
          if (m_wait) begin m_div = m_wait_div; m_high = m_wait_high; m_wait = 0; end
        end
      end
      if (accept) begin m_wait_div = cd; m_wait_high = h; m_wait = 1; end
    end
  endtask

  task automatic step(input bit en, input bit rs, input bit v, input int d, input int h);
    enable      = en;
    restart     = rs;
    cfg_valid   = v;
    cfg_divisor = d[NB-1:0];
    cfg_high    = h[NB-1:0];
    @(posedge clk_FPGA);
    model_update(en, rs, v, d, h);
    #1;
    chk("model_clock_signal", clock_signal, model_clk());
    chk("model_tick", tick, m_tick);
    chk("model_cfg_pending", cfg_pending, m_wait);
    chk("model_cfg_ready", cfg_ready, !m_wait);
    @(negedge clk_FPGA);
  endtask

  // Always advances at least one cycle, then runs to the next tick within a bounded budget
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      step(1, 0, 0, 0, 0);
      n++;
    end while (!tick && n < 16);
    chk(tag, tick, 1);
  endtask

  initial begin
    // Reset values while reset is held
    #1;
    chk("rst_clock_signal", clock_signal, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_pending", cfg_pending, 0);
    @(negedge clk_FPGA);
    @(negedge clk_FPGA);
    model_reset();
    reset = 1'b1;

    // Default 10-cycle period: 0x5 then 1x5, tick on the first cycle of each period
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 0, 0);
      chk("dflt_pattern", clock_signal, (k % 10) >= 5);
      chk("dflt_tick", tick, (k % 10) == 0);
    end

    // Mid-period transfer div=4 high=1, then freeze with it pending
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 4, 1);
    chk("xfer_pending", cfg_pending, 1);
    chk("xfer_ready", cfg_ready, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, (k == 3), 9, 9);
      chk("frz_clock", clock_signal, 1);
      chk("frz_tick", tick, 0);
      chk("frz_pending", cfg_pending, 1);
    end
    wait_tick("div4_wrap_reached");
    chk("div4_applied_pending", cfg_pending, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 0, 0, 0);
      chk("div4_pattern", clock_signal, (i % 4) == 3);
      chk("div4_tick", tick, (i % 4) == 0);
    end

    // Transfer on the wrap cycle: captured, applied only at the following wrap; div=1 clamps to 2
    step(1, 0, 1, 1, 0);
    chk("wrap_xfer_tick", tick, 1);
    chk("wrap_xfer_pending", cfg_pending, 1);
    wait_tick("div2_wrap_reached");
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 0);
      chk("div2_const_low", clock_signal, 0);
      chk("div2_tick", tick, (i % 2) == 0);
    end

    // high >= divisor saturates high
    step(1, 0, 1, 3, 5);
    wait_tick("div3_wrap_reached");
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 0);
      chk("div3_const_high", clock_signal, 1);
      chk("div3_tick", tick, (i % 3) == 0);
    end

    // Restart with a simultaneous transfer applies immediately
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 1, 1, 6, 3);
    chk("rs_tick", tick, 0);
    chk("rs_pending", cfg_pending, 0);
    chk("rs_clock", clock_signal, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 0);
      chk("div6_pattern", clock_signal, (i % 6) >= 3);
      chk("div6_tick", tick, (i % 6) == 0);
    end

    // Asynchronous reset mid-period with a configuration pending
    step(1, 0, 1, 5, 2);
    repeat (2) step(1, 0, 0, 0, 0);
    chk("pre_rst_clock", clock_signal, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_clock", clock_signal, 0);
    chk("async_rst_ready", cfg_ready, 1);
    chk("async_rst_pending", cfg_pending, 0);
    chk("async_rst_tick", tick, 0);
    model_reset();
    @(negedge clk_FPGA);
    @(negedge clk_FPGA);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 0, 0);
      chk("post_rst_pattern", clock_signal, (k % 10) >= 5);
      chk("post_rst_tick", tick, (k % 10) == 0);
    end

    // Random stimulus against the reference model
    for (int r = 0; r < 400; r++) begin
      step(($urandom % 8) != 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
           int'($urandom % 13), int'($urandom % 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Runtime-programmable clock/tick generator. Parametrised successor of the fixed-ratio divider.
- Divides clk_FPGA by a divisor loaded at runtime and generates an output with a programmable high time (duty cycle).
- Emits a one-cycle period-start tick and accepts new settings through a valid/ready handshake.
- New settings take effect only at a period boundary, so the output never glitches. Feeds display scanning, UART baud and PWM logic.

Parameters:
- REFERENCE_CLOCK, 50_000_000, clk_FPGA frequency in Hz.
- DEFAULT_FREQUENCY, 100, output frequency after reset in Hz.
- DEFAULT_DIVISOR, REFERENCE_CLOCK/DEFAULT_FREQUENCY, clk_FPGA cycles per output period after reset.
- NBITS, 26, width of the counter, divisor and high-time fields. DEFAULT_DIVISOR must be < 2**NBITS.

Ports:
- clk_FPGA  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = count; 0 = freeze counter and output.
- restart  input  1  synchronous period restart.
- cfg_valid  input  1  new configuration offered.
- cfg_ready  output  1  block can accept a configuration.
- cfg_divisor  input  NBITS  requested period in clk_FPGA cycles.
- cfg_high  input  NBITS  requested high time in clk_FPGA cycles.
- cfg_pending  output  1  accepted configuration waiting for the next boundary.
- clock_signal  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the first cycle of each period, registered.

Behaviour:
- Reset (async, reset=0):
  - cnt=0, div_active=DEFAULT_DIVISOR, high_active=DEFAULT_DIVISOR/2.
  - Shadow registers cleared. cfg_pending=0, cfg_ready=1, clock_signal=0, tick=0.
- Output rule, true in every cycle after reset:
  - clock_signal = 1 if high_active >= div_active.
  - Otherwise clock_signal = (cnt >= div_active - high_active). The low phase comes first in each period.
  - high_active=0 gives a constant 0.
  - Implementation registers clock_signal from next-state values, so it is aligned with cnt with no extra latency.
- Counting:
  - With enable=1, cnt increments each cycle.
  - When cnt == div_active-1 (wrap), next cnt=0 and tick=1 for exactly that cnt=0 cycle.
  - With enable=0: cnt, clock_signal and active settings hold; tick=0.
- Handshake:
  - cfg_ready = !cfg_pending.
  - Transfer occurs when cfg_valid && cfg_ready. cfg_divisor/cfg_high are captured into shadow registers and cfg_pending=1 from the next cycle.
  - While cfg_pending=1, cfg_valid is ignored and no capture happens.
- Clamping: a captured divisor < 2 is stored as 2. cfg_high is stored unclamped; the output rule handles high >= divisor.
- Apply:
  - While cfg_pending=1, at the next wrap with enable=1: div_active/high_active load from the shadow in the same edge as cnt→0, and cfg_pending→0.
  - The new period starts with the new settings. The output rule uses the new values from that cnt=0 cycle.
  - If enable=0, a pending configuration stays pending; it is not applied while frozen.
- restart=1 (overrides enable):
  - Next cnt=0, tick=0.
  - A pending configuration is applied immediately and cfg_pending→0.
  - A configuration transferred in the same cycle as restart is also applied immediately; cfg_pending stays 0.
  - clock_signal follows the output rule with the resulting settings.
- Simultaneous wrap and transfer (cfg_pending was 0): the transfer is captured, does not apply at this wrap, and applies at the following wrap.
- Reset mid-period: all state returns to reset values asynchronously, and any pending configuration is lost.
- No arithmetic overflow: cnt never exceeds div_active-1. If div_active shrinks at restart, cnt is already 0.

Test Plan:
- Bench parameters: REFERENCE_CLOCK=1000, DEFAULT_FREQUENCY=100 (DEFAULT_DIVISOR=10), NBITS=8.
- Reset release, enable=1 -> clock_signal pattern 0×5, 1×5 repeating. tick on cnt=0 of each period, first tick 10 cycles after the first enabled edge. cfg_ready=1.
- Transfer div=4, high=1 mid-period -> cfg_pending=1 and cfg_ready=0 until the wrap. Current 10-cycle period completes unchanged, then pattern 0,0,0,1 repeats. cfg_pending=0 after the wrap.
- enable=0 for 7 cycles mid-period with a pending configuration -> cnt/clock_signal frozen, no tick, configuration still pending. Resumes exactly where stopped.
- Transfer div=1, high=0 -> stored div=2, output constant 0, tick every 2 cycles. Then transfer high=5 with div=3 -> output constant 1.
- restart asserted together with cfg_valid (div=6, high=3) -> next cycle cnt=0, tick=0, cfg_pending=0. Pattern 0,0,0,1,1,1 starts immediately.
- Assert reset mid-period with a configuration pending -> outputs 0 immediately, cfg_ready=1. After release, default 10-cycle pattern; the pending configuration is never applied.
